// File: rtl/filter_drop_gate.sv
// Drop gate behind a packet filter: forwards or discards whole AXI-Stream packets based on
// the tuser drop flag of the first beat. Define FILTER_DROP_GATE_STATS_EN to build pass/drop counters.
module filter_drop_gate #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DROP_BIT             = 32
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic                              gate_en,
    output logic [31:0]                       pass_count,
    output logic [31:0]                       drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [C_M_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] tstrb_q, tstrb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
    logic                             tvalid_q, tvalid_d;
    logic                             tlast_q, tlast_d;

    logic accept;
    logic drop_first;
    logic load;

    // A dropping packet never needs the output register, so it drains even while egress stalls.
    assign s_axis_tready = !axi_reset &&
                           ((state_q == ST_DROP) || !tvalid_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign drop_first    = gate_en && s_axis_tuser[DROP_BIT];

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q && !m_axis_tready;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (drop_first) begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        load    = 1'b1;
                        state_d = s_axis_tlast ? ST_IDLE : ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_tdata;
            tstrb_d  = s_axis_tstrb;
            tuser_d  = s_axis_tuser;
            tlast_d  = s_axis_tlast;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = tstrb_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

`ifdef FILTER_DROP_GATE_STATS_EN
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        pkt_end;

    // A packet is counted once, on its accepted tlast beat; counters wrap freely.
    always_comb begin
        pkt_end    = accept && s_axis_tlast;
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (pkt_end && ((state_q == ST_PASS) || ((state_q == ST_IDLE) && !drop_first))) begin
            pass_cnt_d = pass_cnt_q + 32'd1;
        end
        if (pkt_end && ((state_q == ST_DROP) || ((state_q == ST_IDLE) && drop_first))) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pass_count = pass_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign pass_count = 32'd0;
    assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_filter_drop_gate.sv
// Self-checking bench for filter_drop_gate: packet-level reference model with expected/observed beat queues.
`timescale 1ns/1ps
module tb_filter_drop_gate;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;
`ifdef FILTER_DROP_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          gate_en;
    logic [31:0]   pass_count;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    filter_drop_gate dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .gate_en       (gate_en),
        .pass_count    (pass_count),
        .drop_count    (drop_count)
    );

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    exp_pass, exp_drop;
    bit    m_in_pkt, m_drop;
    int    lat_err, stab_err, drop_rdy_err, rst_rdy_err, bb_stall, timeouts;
    bit    last_acc, last_rdy, chk_bb;
    int    ready_mode;  // 0 = hold m_axis_tready, 1 = toggle each cycle, 2 = random

    // One clock cycle: enter at negedge, sample before the edge, update the model, observe after.
    task automatic cycle();
        beat_t in_b, pre_out, post_out;
        bit rdy, mv, mr, acc, fwd, rst;
        if (ready_mode == 1) m_axis_tready = ~m_axis_tready;
        else if (ready_mode == 2) m_axis_tready = ($urandom_range(0, 3) != 0);
        #1;
        rdy = s_axis_tready; mv = m_axis_tvalid; mr = m_axis_tready; rst = axi_reset;
        in_b    = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
        pre_out = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
        acc = s_axis_tvalid && rdy && !rst;
        last_acc = acc;
        last_rdy = rdy;
        if (rst && rdy) rst_rdy_err++;
        if (!rst && m_in_pkt && m_drop && !rdy) drop_rdy_err++;
        if (!rst && chk_bb && s_axis_tvalid && !rdy) bb_stall++;
        if (!rst && mv && mr) obs_q.push_back(pre_out);
        fwd = 1'b0;
        if (rst) begin
            m_in_pkt = 1'b0;
            exp_pass = 0;
            exp_drop = 0;
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end else if (acc) begin
            if (!m_in_pkt) m_drop = gate_en && s_axis_tuser[32];
            fwd = !m_drop;
            if (fwd) exp_q.push_back(in_b);
            if (s_axis_tlast) begin
                if (m_drop) exp_drop++;
                else exp_pass++;
            end
            m_in_pkt = !s_axis_tlast;
        end
        @(posedge clk);
        #1;
        post_out = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
        if (fwd && (!m_axis_tvalid || post_out !== in_b)) lat_err++;
        if (!rst && mv && !mr && (!m_axis_tvalid || post_out !== pre_out)) stab_err++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic rand_beat(input bit dropbit, input bit last);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s_axis_tstrb  = $urandom;
        s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tuser[32] = dropbit;
    endtask

    task automatic send_beat(input bit dropbit, input bit last);
        int n = 0;
        rand_beat(dropbit, last);
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 64);
        if (!last_acc) timeouts++;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit dropbit, input int gapmax);
        for (int i = 0; i < len; i++) begin
            send_beat((i == 0) ? dropbit : 1'($urandom_range(0, 1)), i == len - 1);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
    endtask

    task automatic clear();
        axi_reset = 1'b1;
        s_axis_tvalid = 1'b0;
        ready_mode = 0;
        m_axis_tready = 1'b1;
        chk_bb = 1'b0;
        cycle();
        cycle();
        axi_reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        lat_err = 0; stab_err = 0; drop_rdy_err = 0; rst_rdy_err = 0; bb_stall = 0; timeouts = 0;
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        rand_beat(1'b0, 1'b0);
        m_axis_tready = 1'b1;
        rst_rdy_err = 0;
        repeat (3) cycle();
        vectors++;
        if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valid_last got %b want 00", {m_axis_tvalid, m_axis_tlast});
        end
        vectors++;
        if (m_axis_tdata !== '0 || m_axis_tstrb !== '0 || m_axis_tuser !== '0) begin
            miscompares++;
            $display("FAIL reset_payload got data %h user %h want 0", m_axis_tdata[63:0], m_axis_tuser);
        end
        vectors++;
        if (pass_count !== 32'd0 || drop_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", pass_count, drop_count);
        end
        vectors++;
        if (s_axis_tready !== 1'b0 || rst_rdy_err !== 0) begin
            miscompares++;
            $display("FAIL reset_tready got %b (%0d cycles high) want 0", s_axis_tready, rst_rdy_err);
        end
        axi_reset = 1'b0;
        idle(1);
    endtask

    task automatic test_pass_3beat();
        clear();
        gate_en = 1'b1;
        send_pkt(3, 1'b0, 0);
        idle(3);
        vectors++;
        if (obs_q.size() !== 3) begin
            miscompares++;
            $display("FAIL pass3_nbeats got %0d want 3", obs_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL pass3_beat%0d got %h want %h", i, obs_q[i].data[63:0], exp_q[i].data[63:0]);
            end
        end
        vectors++;
        if (lat_err !== 0 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL pass3_latency got %0d late beats %0d timeouts want 0", lat_err, timeouts);
        end
        vectors++;
        if (pass_count !== (STATS ? 32'd1 : 32'd0) || drop_count !== 32'd0) begin
            miscompares++;
            $display("FAIL pass3_counters got %0d/%0d want %0d/0", pass_count, drop_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_drop_then_pass();
        clear();
        gate_en = 1'b1;
        send_pkt(4, 1'b1, 0);
        send_pkt(2, 1'b0, 0);
        idle(3);
        vectors++;
        if (obs_q.size() !== 2) begin
            miscompares++;
            $display("FAIL drop_pass_nbeats got %0d want 2", obs_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL drop_pass_beat%0d got %h want %h", i, obs_q[i].data[63:0], exp_q[i].data[63:0]);
            end
        end
        vectors++;
        if (pass_count !== (STATS ? 32'd1 : 32'd0) || drop_count !== (STATS ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL drop_pass_counters got %0d/%0d want %0d/%0d", pass_count, drop_count,
                     STATS ? 1 : 0, STATS ? 1 : 0);
        end
    endtask

    task automatic test_single_drop_stalled();
        clear();
        gate_en = 1'b1;
        m_axis_tready = 1'b0;
        send_beat(1'b1, 1'b1);
        vectors++;
        if (last_rdy !== 1'b1 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL single_drop_tready got %b want 1", last_rdy);
        end
        idle(3);
        vectors++;
        if (m_axis_tvalid !== 1'b0 || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL single_drop_output got valid %b beats %0d want 0/0", m_axis_tvalid, obs_q.size());
        end
        vectors++;
        if (drop_count !== (STATS ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL single_drop_count got %0d want %0d", drop_count, STATS ? 1 : 0);
        end
        // A following clean single-beat packet is forwarded only if the gate went back to idle.
        m_axis_tready = 1'b1;
        send_beat(1'b0, 1'b1);
        idle(2);
        vectors++;
        if (obs_q.size() !== 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
            miscompares++;
            $display("FAIL single_drop_next_pkt got %0d beats want 1", obs_q.size());
        end
    endtask

    task automatic test_stall_toggle();
        clear();
        gate_en = 1'b1;
        ready_mode = 1;
        send_pkt(6, 1'b0, 0);
        ready_mode = 0;
        m_axis_tready = 1'b1;
        idle(4);
        vectors++;
        if (obs_q.size() !== 6) begin
            miscompares++;
            $display("FAIL toggle_nbeats got %0d want 6", obs_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL toggle_beat%0d got %h want %h", i, obs_q[i].data[63:0], exp_q[i].data[63:0]);
            end
        end
        vectors++;
        if (stab_err !== 0 || lat_err !== 0) begin
            miscompares++;
            $display("FAIL toggle_stability got %0d unstable %0d late want 0/0", stab_err, lat_err);
        end
    endtask

    task automatic test_gate_midpacket();
        clear();
        gate_en = 1'b0;
        send_beat(1'b1, 1'b0);
        gate_en = 1'b1;
        send_beat(1'b1, 1'b0);
        send_beat(1'b1, 1'b0);
        send_beat(1'b1, 1'b1);
        idle(3);
        vectors++;
        if (obs_q.size() !== 4) begin
            miscompares++;
            $display("FAIL gate_mid_nbeats got %0d want 4", obs_q.size());
        end
        vectors++;
        if (pass_count !== (STATS ? 32'd1 : 32'd0) || drop_count !== 32'd0) begin
            miscompares++;
            $display("FAIL gate_mid_counters got %0d/%0d want %0d/0", pass_count, drop_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_reset_midpacket();
        clear();
        gate_en = 1'b1;
        m_axis_tready = 1'b0;
        send_beat(1'b0, 1'b0);
        rand_beat(1'b0, 1'b0);
        axi_reset = 1'b1;
        cycle();
        axi_reset = 1'b0;
        s_axis_tvalid = 1'b0;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || pass_count !== 32'd0 || drop_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_clear got valid %b counts %0d/%0d want 0 0/0",
                     m_axis_tvalid, pass_count, drop_count);
        end
        m_axis_tready = 1'b1;
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b0);
        send_beat(1'b0, 1'b1);
        idle(3);
        vectors++;
        if (obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_output got %0d beats want 0", obs_q.size());
        end
        vectors++;
        if (drop_count !== (STATS ? 32'd1 : 32'd0) || pass_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_counters got %0d/%0d want 0/%0d", pass_count, drop_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        clear();
        gate_en = 1'b1;
        chk_bb = 1'b1;
        for (int p = 0; p < 8; p++) send_pkt($urandom_range(1, 4), 1'($urandom_range(0, 1)), 0);
        chk_bb = 1'b0;
        idle(3);
        vectors++;
        if (bb_stall !== 0 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL b2b_stall got %0d stalled cycles want 0", bb_stall);
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_beat%0d got %h want %h", i, obs_q[i].data[63:0], exp_q[i].data[63:0]);
            end
        end
        vectors++;
        if (pass_count !== (STATS ? exp_pass : 0) || drop_count !== (STATS ? exp_drop : 0)) begin
            miscompares++;
            $display("FAIL b2b_counters got %0d/%0d want %0d/%0d", pass_count, drop_count,
                     STATS ? exp_pass : 0, STATS ? exp_drop : 0);
        end
    endtask

    task automatic test_random();
        int len;
        clear();
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                gate_en = 1'($urandom_range(0, 1));
                send_beat(1'($urandom_range(0, 1)), i == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        ready_mode = 0;
        m_axis_tready = 1'b1;
        idle(4);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_nbeats got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i].data[63:0], exp_q[i].data[63:0]);
            end
        end
        vectors++;
        if (lat_err !== 0 || stab_err !== 0 || drop_rdy_err !== 0 || timeouts !== 0) begin
            miscompares++;
            $display("FAIL rand_protocol got late %0d unstable %0d drop_stall %0d timeouts %0d want 0",
                     lat_err, stab_err, drop_rdy_err, timeouts);
        end
        vectors++;
        if (pass_count !== (STATS ? exp_pass : 0) || drop_count !== (STATS ? exp_drop : 0)) begin
            miscompares++;
            $display("FAIL rand_counters got %0d/%0d want %0d/%0d", pass_count, drop_count,
                     STATS ? exp_pass : 0, STATS ? exp_drop : 0);
        end
    endtask

    initial begin
        axi_reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = '0;
        s_axis_tstrb = '0;
        s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        gate_en = 1'b1;
        ready_mode = 0;
        chk_bb = 1'b0;
        m_in_pkt = 1'b0;
        m_drop = 1'b0;
        exp_pass = 0;
        exp_drop = 0;
        timeouts = 0;
        @(negedge clk);
        test_reset();
        test_pass_3beat();
        test_drop_then_pass();
        test_single_drop_stalled();
        test_stall_toggle();
        test_gate_midpacket();
        test_reset_midpacket();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/filter_drop_gate.md
FILTER_DROP_GATE -- requirements
Module: filter_drop_gate

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master tdata width.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave tdata width; SHALL equal C_M_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameters C_M_AXIS_TUSER_WIDTH and C_S_AXIS_TUSER_WIDTH, default 128 each, tuser widths; SHALL be equal.
REQ-004 SHALL have parameter DROP_BIT, default 32, index of the tuser drop flag set by the upstream filter.
REQ-005 SHALL have ports: axi_aclk  in  1  sole clock, all logic on rising edge.
REQ-006 axi_reset  in  1  reset; synchronous, active-high.
REQ-007 s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  ingress data (from filter).
REQ-008 s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  ingress byte strobes.
REQ-009 s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  ingress metadata; valid on first beat.
REQ-010 s_axis_tvalid  in  1;  s_axis_tready  out  1;  s_axis_tlast  in  1.
REQ-011 m_axis_tdata/tstrb/tuser  out  same widths as slave  egress beat.
REQ-012 m_axis_tvalid  out  1;  m_axis_tready  in  1;  m_axis_tlast  out  1.
REQ-013 gate_en  in  1  1 = honour drop flag, 0 = forward all packets.
REQ-014 pass_count  out  32  packets forwarded;  drop_count  out  32  packets discarded.

Function
REQ-015 Beat transfer on either side SHALL occur only when tvalid and tready are both 1 in the same cycle.
REQ-016 Egress SHALL be a single output register: s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-017 Forwarded beats SHALL appear on m_axis exactly 1 cycle after slave acceptance, data/strb/user/last unmodified.
REQ-018 FSM states: IDLE (awaiting first beat), PASS (forwarding rest of packet), DROP (discarding rest of packet).
REQ-019 IDLE: on accepted beat, drop decision D = gate_en && s_axis_tuser[DROP_BIT], sampled on this beat only.
REQ-020 IDLE, D=0: beat loaded to output register; next state PASS if tlast=0, else IDLE.
REQ-021 IDLE, D=1: beat consumed, not forwarded, m_axis_tvalid unchanged by it; next state DROP if tlast=0, else IDLE.
REQ-022 PASS: every accepted beat loaded to output register; accepted tlast -> IDLE.
REQ-023 DROP: s_axis_tready SHALL be 1 regardless of m_axis_tready; beats discarded; accepted tlast -> IDLE.
REQ-024 gate_en changes mid-packet SHALL NOT affect the packet in progress.
REQ-025 Output register SHALL hold its beat stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 Back-to-back packets SHALL be accepted with no idle cycle between tlast and next first beat.
REQ-027 pass_count SHALL increment by 1 when a tlast beat is accepted in PASS, or in IDLE with D=0.
REQ-028 drop_count SHALL increment by 1 when a tlast beat is accepted in DROP, or in IDLE with D=1.
REQ-029 Counters SHALL wrap 0xFFFFFFFF -> 0x00000000 without saturation or flag.

Reset
REQ-030 While axi_reset=1: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, counters=0.
REQ-031 s_axis_tready SHALL be 0 while axi_reset=1.
REQ-032 Reset mid-packet SHALL discard the held beat; first beat accepted after reset is treated as start of packet.

Configuration
REQ-033 Macro FILTER_DROP_GATE_STATS_EN defined: pass_count/drop_count implemented per REQ-027..029.
REQ-034 Macro undefined: counter registers not built; pass_count and drop_count SHALL be constant 0; datapath behaviour identical.

Verification
REQ-035 gate_en=1, 3-beat packet tuser[32]=0, m_axis_tready=1 -> 3 beats out, 1 cycle latency, pass_count=1.
REQ-036 gate_en=1, 4-beat packet tuser[32]=1 then 2-beat packet tuser[32]=0 back-to-back -> only 2 beats out, drop_count=1, pass_count=1.
REQ-037 Single-beat packet (tlast on first beat) with tuser[32]=1, m_axis_tready=0 -> s_axis_tready=1, no output, drop_count=1, state IDLE.
REQ-038 Forwarded packet with m_axis_tready toggling 1/0 per cycle -> no beat lost or duplicated, output stable while stalled.
REQ-039 gate_en=0, packet tuser[32]=1; gate_en raised mid-packet -> whole packet forwarded, pass_count=1.
REQ-040 axi_reset=1 pulsed during beat 2 of 5-beat packet -> m_axis_tvalid=0 next cycle, counters=0, next beat treated as first beat.
